// File: rtl/stream_framer_pkg.sv
// Shared types and constants for the length-prefixing stream framer.
package stream_framer_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int KEEP_W_DEF  = DATA_W_DEF / 8;
    localparam int HDR_CNT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DISCARD,
        HEADER,
        DRAIN,
        DONE
    } framer_state_e;

endpackage

// File: rtl/frame_buffer_ram.sv
// Payload store: one write port, one registered read port.
module frame_buffer_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write-first on collision so a one-beat packet can be read back right after its write.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end

endmodule

// File: rtl/stream_length_framer.sv
// Buffers one AXI-Stream packet and re-emits it behind a beat-count header word.
//
// state   | meaning
// IDLE    | waiting for frame_en
// FILL    | storing input beats, counting them
// DISCARD | buffer full, dropping beats until tlast
// HEADER  | presenting the length word
// DRAIN   | replaying buf[0..cnt-1]
// DONE    | frame complete, holding frame_done
module stream_length_framer
    import stream_framer_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int DATA_W  = DATA_W_DEF,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              frame_en,
    output logic              frame_done,
    output logic              overflow,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    framer_state_e     state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  rd_addr_d;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] hdr_word;
    logic              s_fire;
    logic              m_fire;
    logic              wr_en;

    assign s_fire  = s_axis_tvalid && s_axis_tready;
    assign m_fire  = m_axis_tvalid && m_axis_tready;
    assign wr_en   = s_fire && (state == FILL);
    assign cnt_inc = cnt + 1'b1;
    assign hdr_cnt = (state == FILL) ? cnt_inc : cnt;

    always_comb begin
        wr_data = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            wr_data[b*8 +: 8] = s_axis_tkeep[b] ? s_axis_tdata[b*8 +: 8] : 8'h00;
        end
    end

    always_comb begin
        hdr_word = '0;
        hdr_word[HDR_CNT_LSB +: CNT_W] = hdr_cnt;
    end

    // rd_data always holds buf[rd_ptr]; advancing on each output load keeps DRAIN bubble-free.
    always_comb begin
        rd_addr_d = rd_ptr;
        if (m_fire && ((state == HEADER) || ((state == DRAIN) && !m_axis_tlast))) begin
            rd_addr_d = rd_ptr + 1'b1;
        end
    end

    frame_buffer_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_buf (
        .sys_clk (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr_d[AW-1:0]),
        .rd_data (rd_data)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rd_ptr        <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else if (!frame_en) begin
            state         <= IDLE;
            cnt           <= '0;
            rd_ptr        <= '0;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            rd_ptr <= rd_addr_d;
            case (state)
                IDLE: begin
                    state         <= FILL;
                    s_axis_tready <= 1'b1;
                end
                FILL, DISCARD: begin
                    if (s_fire) begin
                        if (state == FILL) cnt <= cnt_inc;
                        if (s_axis_tlast) begin
                            state         <= HEADER;
                            s_axis_tready <= 1'b0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= hdr_word;
                            m_axis_tkeep  <= '1;
                            m_axis_tlast  <= 1'b0;
                        end else if ((state == FILL) && (cnt_inc == CNT_W'(DEPTH))) begin
                            overflow <= 1'b1;
                            state    <= DISCARD;
                        end
                    end
                end
                HEADER, DRAIN: begin
                    if (m_fire) begin
                        if ((state == DRAIN) && m_axis_tlast) begin
                            state         <= DONE;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            frame_done    <= 1'b1;
                        end else begin
                            state        <= DRAIN;
                            m_axis_tdata <= rd_data;
                            m_axis_tlast <= (rd_ptr == cnt - 1'b1);
                        end
                    end
                end
                DONE: frame_done <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_length_framer.sv
// Self-checking bench for stream_length_framer: directed tables, corner sequences, random frames vs model.
module tb_stream_length_framer;

    localparam int DEPTH = 16;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        frame_en;
    logic        frame_done;
    logic        overflow;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;

    int errors = 0;
    int checks = 0;

    logic [63:0] in_data[$];
    logic [7:0]  in_keep[$];
    logic [63:0] exp_q[$];
    logic        exp_ovf;
    logic [63:0] got_d[$];
    logic        got_l[$];
    logic [7:0]  got_k[$];

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [63:0] word;
    } keep_vec_t;
    keep_vec_t kv[5];

    always #5 sys_clk = ~sys_clk;

    stream_length_framer #(.DEPTH(DEPTH), .DATA_W(64)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .frame_en      (frame_en),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Reference: header = stored beat count, then stored words with unkept bytes zeroed.
    function automatic logic [63:0] keep_mask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) if (k[b]) r = r | (d & (64'hFF << (8 * b)));
        return r;
    endfunction

    task automatic build_expected();
        int n;
        int kept;
        n    = in_data.size();
        kept = (n > DEPTH) ? DEPTH : n;
        exp_q.delete();
        exp_q.push_back(64'(kept));
        for (int i = 0; i < kept; i++) exp_q.push_back(keep_mask(in_data[i], in_keep[i]));
        exp_ovf = (n > DEPTH);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_tready"}, 64'(s_axis_tready), 0);
        chk({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 0);
        chk({tag, "_m_tdata"},  m_axis_tdata, 0);
        chk({tag, "_m_tkeep"},  64'(m_axis_tkeep), 0);
        chk({tag, "_m_tlast"},  64'(m_axis_tlast), 0);
        chk({tag, "_done"},     64'(frame_done), 0);
        chk({tag, "_ovf"},      64'(overflow), 0);
    endtask

    task automatic start_frame();
        frame_en = 1'b0;
        step();
        frame_en = 1'b1;
        step();
        chk("fill_ready", 64'(s_axis_tready), 1);
    endtask

    task automatic end_frame();
        frame_en = 1'b0;
        step();
        chk("clr_done",   64'(frame_done), 0);
        chk("clr_ovf",    64'(overflow), 0);
        chk("clr_valid",  64'(m_axis_tvalid), 0);
        chk("clr_sready", 64'(s_axis_tready), 0);
    endtask

    task automatic send_packet(input int gap_pct);
        int w;
        for (int i = 0; i < in_data.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                step();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = in_data[i];
            s_axis_tkeep  = in_keep[i];
            s_axis_tlast  = (i == in_data.size() - 1);
            w = 0;
            while (!s_axis_tready && w < 20) begin
                step();
                w++;
            end
            if (!s_axis_tready) begin
                chk("s_ready_timeout", 64'(s_axis_tready), 1);
                break;
            end
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("hdr_valid_next_cycle", 64'(m_axis_tvalid), 1);
    endtask

    task automatic collect(input int ready_pct, input int limit);
        int          cyc;
        logic        stalled;
        logic [63:0] hd;
        logic        hl;
        got_d.delete();
        got_l.delete();
        got_k.delete();
        cyc     = 0;
        stalled = 1'b0;
        hd      = '0;
        hl      = 1'b0;
        while (got_d.size() < limit && cyc < 2000) begin
            m_axis_tready = ($urandom_range(99) < ready_pct);
            if (stalled) begin
                chk("stall_valid", 64'(m_axis_tvalid), 1);
                chk("stall_data",  m_axis_tdata, hd);
                chk("stall_last",  64'(m_axis_tlast), 64'(hl));
            end
            if (ready_pct == 100 && got_d.size() > 0) chk("no_bubble", 64'(m_axis_tvalid), 1);
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
                got_k.push_back(m_axis_tkeep);
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            hd      = m_axis_tdata;
            hl      = m_axis_tlast;
            step();
            cyc++;
        end
        m_axis_tready = 1'b0;
        if (got_d.size() < limit) chk("collect_timeout", 64'(got_d.size()), 64'(limit));
    endtask

    task automatic compare_output(input string tag);
        chk({tag, "_len"}, 64'(got_d.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), got_d[i], exp_q[i]);
            chk($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(i == exp_q.size() - 1));
            chk($sformatf("%s_keep%0d", tag, i), 64'(got_k[i]), 64'hFF);
        end
        chk({tag, "_done"},       64'(frame_done), 1);
        chk({tag, "_idle_valid"}, 64'(m_axis_tvalid), 0);
        chk({tag, "_ovf"},        64'(overflow), 64'(exp_ovf));
    endtask

    task automatic run_frame(input string tag, input int ready_pct, input int gap_pct);
        start_frame();
        send_packet(gap_pct);
        collect(ready_pct, exp_q.size());
        compare_output(tag);
        end_frame();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        kv[0] = '{64'hFFFF_FFFF_1234_5678, 8'h0F, 64'h0000_0000_1234_5678};
        kv[1] = '{64'h0000_0000_0000_0007, 8'hFF, 64'h0000_0000_0000_0007};
        kv[2] = '{64'h0123_4567_89AB_CDEF, 8'hF0, 64'h0123_4567_0000_0000};
        kv[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0000_0000_0000_0000};
        kv[4] = '{64'hAABB_CCDD_EEFF_0011, 8'h81, 64'hAA00_0000_0000_0011};

        sys_rst_n     = 1'b0;
        frame_en      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        #23;
        chk_all_zero("reset");
        step();
        sys_rst_n = 1'b1;
        step();

        // 4-beat packet with a negative last word, expectations written out by hand.
        in_data = '{64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC};
        in_keep = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_q   = '{64'd4, 64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC};
        exp_ovf = 1'b0;
        run_frame("four_beat", 100, 0);

        // Single-beat packets exercising byte masking.
        for (int v = 0; v < 5; v++) begin
            in_data = '{kv[v].data};
            in_keep = '{kv[v].keep};
            exp_q   = '{64'd1, kv[v].word};
            exp_ovf = 1'b0;
            run_frame($sformatf("keep%0d", v), 100, 0);
        end

        // Overflow: 18 beats into a 16-deep buffer.
        in_data.delete();
        in_keep.delete();
        for (int i = 1; i <= DEPTH + 2; i++) begin
            in_data.push_back(64'(i));
            in_keep.push_back(8'hFF);
        end
        build_expected();
        chk("ovf_model_hdr", exp_q[0], 64'(DEPTH));
        run_frame("overflow", 100, 0);

        // Exactly DEPTH beats with random stalls on the output.
        in_data.delete();
        in_keep.delete();
        for (int i = 0; i < DEPTH; i++) begin
            in_data.push_back({$urandom, $urandom});
            in_keep.push_back(8'hFF);
        end
        build_expected();
        run_frame("stall16", 50, 0);

        // Random frames against the model.
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, DEPTH + 4);
            in_data.delete();
            in_keep.delete();
            for (int i = 0; i < n; i++) begin
                in_data.push_back({$urandom, $urandom});
                in_keep.push_back(($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'hFF);
            end
            build_expected();
            run_frame($sformatf("rand%0d", f), $urandom_range(30, 100), $urandom_range(0, 30));
        end

        // Abort mid-DRAIN, then a clean 2-beat frame.
        start_frame();
        in_data = '{64'd11, 64'd12, 64'd13, 64'd14};
        in_keep = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_packet(0);
        collect(100, 3);
        chk("abort_w0", got_d[0], 64'd4);
        chk("abort_w2", got_d[2], 64'd12);
        frame_en = 1'b0;
        step();
        chk("abort_valid",  64'(m_axis_tvalid), 0);
        chk("abort_sready", 64'(s_axis_tready), 0);
        chk("abort_done",   64'(frame_done), 0);
        in_data = '{64'd5, 64'd6};
        in_keep = '{8'hFF, 8'hFF};
        exp_q   = '{64'd2, 64'd5, 64'd6};
        exp_ovf = 1'b0;
        run_frame("after_abort", 100, 0);

        // Asynchronous reset in the middle of FILL.
        start_frame();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'h55;
        s_axis_tkeep  = 8'hFF;
        step();
        step();
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        s_axis_tvalid = 1'b0;
        frame_en      = 1'b0;
        step();
        sys_rst_n = 1'b1;
        step();
        chk("post_rst_sready", 64'(s_axis_tready), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
